muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the EX-stage multi-cycle multiply/divide unit. Accepts one MUL/MADD/MSUB/DIV issue from the EX stage and latches its operands and HI/LO snapshot. Holds the unit's op and operands stable while the unit runs, stalls the pipeline, and produces a one-cycle HI/LO write on completion. Exception flush aborts the operation with no architectural write.

## Interface
- DIV_CYCLES, 36: minimum RUN cycles for `OP_DIV`; must be ≥ 2.
- MUL_CYCLES, 2: minimum RUN cycles for `OP_MUL`/`OP_MADD`/`OP_MSUB`; must be ≥ 1.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- exception_flush  in  1  pipeline flush; aborts any in-flight operation.
- issue_valid  in  1  EX stage presents an instruction this cycle.
- issue_op  in  8  `OP_*` code from defs.v.
- issue_unsigned  in  1  unsigned flag of the issued instruction.
- issue_a, issue_b  in  32 each  source operands.
- hilo_i  in  64  current HI/LO, already forwarded; {HI,LO}.
- unit_result  in  64  multi-cycle unit result.
- unit_done  in  1  multi-cycle unit done.
- unit_op  out  8  op to the unit; 8'h00 (`OP_NOP`) when not RUN.
- unit_unsigned  out  1  latched unsigned flag.
- unit_a, unit_b  out  32 each  latched operands.
- unit_hilo  out  64  latched HI/LO snapshot.
- unit_flush  out  1  exception_flush & (state != IDLE).
- stall_o  out  1  hold IF/ID/EX.
- busy  out  1  state != IDLE.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- hilo_wdata  out  64  registered result for HI/LO.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Accepted ops: `OP_MUL`, `OP_MADD`, `OP_MSUB`, `OP_DIV`. Any other issue_op is ignored: no stall, stay IDLE.
- IDLE, issue_valid & accepted op & !exception_flush:
  - latch op, unsigned flag, issue_a, issue_b and hilo_i into the unit_* registers;
  - load cnt = (op==`OP_DIV` ? DIV_CYCLES : MUL_CYCLES) − 1;
  - go to RUN.
- RUN:
  - unit_op and operands are held constant;
  - cnt decrements each cycle, saturating at 0;
  - when cnt==0 & unit_done: capture hilo_wdata ← unit_result, set unit_op ← `OP_NOP`, go to DONE;
  - when cnt==0 & !unit_done: stay in RUN with the op held until unit_done.
- DONE: hilo_we=1 for exactly this cycle, then go to IDLE. An issue arriving in DONE is not accepted; it is accepted on the following IDLE cycle.
- exception_flush in any state, or simultaneous with an issue:
  - next state IDLE; unit_op ← `OP_NOP`; cnt ← 0;
  - no hilo_we in the following cycle;
  - flush beats completion: a flush in the RUN cycle that would complete suppresses the write;
  - a flush during DONE does not cancel that cycle's hilo_we, because that write is already committed.
- issue_valid is ignored in RUN and DONE. The pipeline is stalled there, so a new issue is a protocol violation.
- Widths: no arithmetic on data in this block; hilo_wdata is copied bit-exact from unit_result. cnt width is clog2(DIV_CYCLES).

## Timing
- Reset (async, rst_n low): state IDLE, cnt 0, unit_op 8'h00, unit_unsigned 0, unit_a/unit_b 0, unit_hilo 0, hilo_wdata 0, hilo_we 0, stall_o 0, busy 0, unit_flush 0.
- stall_o is combinational: 1 in the IDLE accept cycle T (issue_valid & accepted op & !exception_flush), 1 throughout RUN, 0 in DONE and idle IDLE.
- Issue at T: unit sees the op from T+1. RUN occupies T+1 … T+N with N = MUL_CYCLES or DIV_CYCLES, plus extra cycles if unit_done is late.
- Result is captured on the edge ending the last RUN cycle. DONE (hilo_we=1, stall_o=0) is at T+N+1, and the EX instruction retires on that edge.
- Back-to-back ops: the next accept is possible at T+N+2, giving a minimum of N+2 cycles per op.
- hilo_we, hilo_wdata, unit_* and busy are registered. stall_o and unit_flush are combinational.

## Test plan
- MUL after reset, MUL_CYCLES=2: issue `OP_MUL` a=0xFFFFFFFE, b=3, signed, at T; unit_done returns at T+2 with result 0xFFFFFFFF_FFFFFFFA. Required: stall_o=1 at T..T+2; hilo_we=1 at T+3 only, with hilo_wdata=0xFFFFFFFF_FFFFFFFA.
- DIV, DIV_CYCLES=36: a=100, b=7, unsigned; unit_done at T+36 with result {32'd2, 32'd14}. Required: unit_op=`OP_DIV` T+1..T+36; hilo_we at T+37 with hilo_wdata=0x00000002_0000000E.
- Late unit_done: DIV where unit_done arrives at T+40. Required: state stays RUN through T+40, hilo_we at T+41, and stall_o continuous until then.
- Flush mid-DIV: exception_flush at T+10. Required: unit_flush=1 at T+10; unit_op=0 and busy=0 at T+11; no hilo_we afterwards; a new `OP_MUL` issued at T+11 is accepted normally.
- Flush in accept cycle / non-muldiv op: issue `OP_MADD` together with exception_flush → state stays IDLE, stall_o=0. Issue op 8'h01 (not accepted) → no stall, no state change.
- Async reset asserted mid-RUN, between clock edges: all outputs reach their reset values immediately, before the next edge; after release, a MADD with hilo_i=0x0000000A_00000000 latches unit_hilo=0x0000000A_00000000.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Sequencer for the EX-stage multi-cycle multiply/divide unit. It accepts one
// MUL/MADD/MSUB/DIV issue, latches the operands and the forwarded HI/LO
// snapshot, and holds them stable while the unit runs. It stalls the pipeline
// for the duration of the operation and then produces a one-cycle HI/LO write.
// An exception flush aborts the operation without an architectural write.
//
// Handshake: an issue is taken only in IDLE when issue_valid is high, the op
// is a mul/div op and exception_flush is low. In that same cycle stall_o
// rises, so the EX stage holds the instruction until DONE. The unit is driven
// with a non-NOP unit_op for the whole RUN phase. unit_done counts only once
// the minimum-cycle counter has reached zero. The bench side never needs to
// hold issue_valid, because the take is single-cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   exception_flush       abort any in-flight operation
//   issue_valid/op/...    EX-stage issue: op code, unsigned flag, operands
//   hilo_i                forwarded {HI,LO}
//   unit_result/done      result and completion from the multi-cycle unit
//   unit_op/unsigned/a/b  latched command to the unit (op is NOP outside RUN)
//   unit_hilo             latched HI/LO snapshot for MADD/MSUB
//   unit_flush            flush forwarded to the unit while it is busy
//   stall_o               hold IF/ID/EX (combinational)
//   busy                  sequencer not idle
//   hilo_we/hilo_wdata    one-cycle registered HI/LO write
//   dbg_state_o           current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int unsigned DIV_CYCLES = 36,
  parameter int unsigned MUL_CYCLES = 2,
  parameter logic [7:0]  OP_NOP     = 8'h00,
  parameter logic [7:0]  OP_MUL     = 8'h10,
  parameter logic [7:0]  OP_MADD    = 8'h11,
  parameter logic [7:0]  OP_MSUB    = 8'h12,
  parameter logic [7:0]  OP_DIV     = 8'h13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exception_flush,
  input  logic        issue_valid,
  input  logic [7:0]  issue_op,
  input  logic        issue_unsigned,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [63:0] hilo_i,
  input  logic [63:0] unit_result,
  input  logic        unit_done,
  output logic [7:0]  unit_op,
  output logic        unit_unsigned,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic [63:0] unit_hilo,
  output logic        unit_flush,
  output logic        stall_o,
  output logic        busy,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  // Counter preload is N-1: RUN spans N cycles and completes on the cycle
  // where the counter reads zero.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic        uns_q, uns_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] hilo_q, hilo_d;
  logic [63:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        op_ok;
  logic        accept;

  assign op_ok = (issue_op == OP_MUL) || (issue_op == OP_MADD) ||
                 (issue_op == OP_MSUB) || (issue_op == OP_DIV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    uns_d   = uns_q;
    a_d     = a_q;
    b_d     = b_q;
    hilo_d  = hilo_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (issue_valid && op_ok && !exception_flush) begin
          accept  = 1'b1;
          state_d = ST_RUN;
          op_d    = issue_op;
          uns_d   = issue_unsigned;
          a_d     = issue_a;
          b_d     = issue_b;
          hilo_d  = hilo_i;
          cnt_d   = (issue_op == OP_DIV) ? DIV_LOAD : MUL_LOAD;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          // Minimum time elapsed; wait as long as the unit needs.
          if (unit_done) begin
            wdata_d = unit_result;
            op_d    = OP_NOP;
            we_d    = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush wins over completion. A flush seen in DONE cannot retract the
    // write strobe that is already on hilo_we this cycle.
    if (exception_flush) begin
      state_d = ST_IDLE;
      op_d    = OP_NOP;
      cnt_d   = '0;
      we_d    = 1'b0;
      wdata_d = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      uns_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hilo_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      uns_q   <= uns_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hilo_q  <= hilo_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign unit_op       = op_q;
  assign unit_unsigned = uns_q;
  assign unit_a        = a_q;
  assign unit_b        = b_q;
  assign unit_hilo     = hilo_q;
  assign hilo_we       = we_q;
  assign hilo_wdata    = wdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign unit_flush    = exception_flush && (state_q != ST_IDLE);
  // The accept cycle stalls too, so EX holds the instruction until it retires
  // on the edge that ends DONE.
  assign stall_o       = accept || (state_q == ST_RUN);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  localparam int unsigned DIV_N = 36;
  localparam int unsigned MUL_N = 2;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MUL  = 8'h10;
  localparam logic [7:0] OP_MADD = 8'h11;
  localparam logic [7:0] OP_MSUB = 8'h12;
  localparam logic [7:0] OP_DIV  = 8'h13;

  logic        clk;
  logic        rst_n;
  logic        exception_flush;
  logic        issue_valid;
  logic [7:0]  issue_op;
  logic        issue_unsigned;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [63:0] hilo_i;
  logic [63:0] unit_result;
  logic        unit_done;
  logic [7:0]  unit_op;
  logic        unit_unsigned;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [63:0] unit_hilo;
  logic        unit_flush;
  logic        stall_o;
  logic        busy;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic [1:0]  dbg_state_o;

  int total;
  int bad;

  muldiv_ctrl #(
    .DIV_CYCLES (DIV_N),
    .MUL_CYCLES (MUL_N),
    .OP_NOP     (OP_NOP),
    .OP_MUL     (OP_MUL),
    .OP_MADD    (OP_MADD),
    .OP_MSUB    (OP_MSUB),
    .OP_DIV     (OP_DIV)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .exception_flush (exception_flush),
    .issue_valid     (issue_valid),
    .issue_op        (issue_op),
    .issue_unsigned  (issue_unsigned),
    .issue_a         (issue_a),
    .issue_b         (issue_b),
    .hilo_i          (hilo_i),
    .unit_result     (unit_result),
    .unit_done       (unit_done),
    .unit_op         (unit_op),
    .unit_unsigned   (unit_unsigned),
    .unit_a          (unit_a),
    .unit_b          (unit_b),
    .unit_hilo       (unit_hilo),
    .unit_flush      (unit_flush),
    .stall_o         (stall_o),
    .busy            (busy),
    .hilo_we         (hilo_we),
    .hilo_wdata      (hilo_wdata),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    logic [63:0] result;
    int          done_at;   // cycle after issue at which unit_done pulses
  } vec_t;

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT idle. Issues at T, pulses unit_done at
  // T+done_at and checks stall, op, strobe timing and write data.
  task automatic do_op(input vec_t v);
    int n, last, stall_cnt, op_cnt, we_cnt, we_cyc;
    logic [63:0] wd;
    n = (v.op == OP_DIV) ? DIV_N : MUL_N;
    last = (v.done_at > n) ? v.done_at : n;
    stall_cnt = 0; op_cnt = 0; we_cnt = 0; we_cyc = -1; wd = '0;
    unit_result    = v.result;
    issue_valid    = 1'b1;
    issue_op       = v.op;
    issue_unsigned = v.uns;
    issue_a        = v.a;
    issue_b        = v.b;
    hilo_i         = v.hilo;
    @(negedge clk);
    check("accept_stall", stall_o, 1);
    check("accept_busy", busy, 0);
    check("accept_unit_op", unit_op, OP_NOP);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    issue_op    = OP_NOP;
    issue_a     = '0;
    issue_b     = '0;
    hilo_i      = '0;
    for (int k = 1; k <= last + 4; k++) begin
      unit_done = (k == v.done_at);
      @(negedge clk);
      if (k == 1) begin
        check("latch_a", unit_a, v.a);
        check("latch_b", unit_b, v.b);
        check("latch_hilo", unit_hilo, v.hilo);
        check("latch_uns", unit_unsigned, v.uns);
      end
      if (stall_o) stall_cnt++;
      if (unit_op == v.op) op_cnt++;
      if (hilo_we) begin
        we_cnt++;
        we_cyc = k;
        wd = hilo_wdata;
      end
      @(posedge clk); #1;
    end
    unit_done = 1'b0;
    check("run_stall_cycles", stall_cnt, last);
    check("run_op_cycles", op_cnt, last);
    check("we_count", we_cnt, 1);
    check("we_cycle", we_cyc, last + 1);
    check("we_data", wd, v.result);
  endtask

  vec_t vecs[5];

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    exception_flush = 1'b0;
    issue_valid = 1'b0;
    issue_op = OP_NOP;
    issue_unsigned = 1'b0;
    issue_a = '0;
    issue_b = '0;
    hilo_i = '0;
    unit_result = '0;
    unit_done = 1'b0;

    vecs[0] = '{OP_MUL,  1'b0, 32'hFFFFFFFE, 32'd3, 64'h0, 64'hFFFFFFFF_FFFFFFFA, 2};
    vecs[1] = '{OP_DIV,  1'b1, 32'd100, 32'd7, 64'h0, {32'd2, 32'd14}, 36};
    vecs[2] = '{OP_DIV,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h1, 64'h0000_0000_8000_0000, 40};
    vecs[3] = '{OP_MSUB, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 64'h5555_AAAA_0F0F_F0F0, 64'hDEAD_BEEF_CAFE_F00D, 5};
    vecs[4] = '{OP_MADD, 1'b0, 32'h0000_0003, 32'h0000_0004, 64'h0000_0001_0000_0002, 64'h0000_0001_0000_000E, 2};

    // Reset values.
    #2;
    check("rst_unit_op", unit_op, OP_NOP);
    check("rst_busy", busy, 0);
    check("rst_stall", stall_o, 0);
    check("rst_we", hilo_we, 0);
    check("rst_wdata", hilo_wdata, 64'h0);
    check("rst_unit_a", unit_a, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven ops, including late unit_done.
    for (int i = 0; i < 5; i++) do_op(vecs[i]);

    // Flush mid-DIV at T+10, then MUL issued at T+11.
    issue_valid = 1'b1; issue_op = OP_DIV; issue_a = 32'd50; issue_b = 32'd5;
    @(posedge clk); #1;
    issue_valid = 1'b0; issue_op = OP_NOP;
    for (int k = 1; k <= 10; k++) begin
      exception_flush = (k == 10);
      @(negedge clk);
      if (k == 10) begin
        check("flush_unit_flush", unit_flush, 1);
        check("flush_no_we", hilo_we, 0);
      end
      @(posedge clk); #1;
    end
    exception_flush = 1'b0;
    do_op('{OP_MUL, 1'b0, 32'd6, 32'd7, 64'h0, 64'd42, 2});

    // Flush in the completing RUN cycle suppresses the write.
    issue_valid = 1'b1; issue_op = OP_MUL; unit_result = 64'h1111;
    @(posedge clk); #1;
    issue_valid = 1'b0; issue_op = OP_NOP;
    begin
      int we_seen;
      we_seen = 0;
      for (int k = 1; k <= 6; k++) begin
        unit_done = (k == 2);
        exception_flush = (k == 2);
        @(negedge clk);
        if (hilo_we) we_seen++;
        if (k == 3) check("flushdone_busy", busy, 0);
        @(posedge clk); #1;
      end
      unit_done = 1'b0;
      exception_flush = 1'b0;
      check("flushdone_no_we", we_seen, 0);
      check("flushdone_wdata_kept", hilo_wdata, 64'd42);
    end

    // Flush during DONE keeps that cycle's write.
    issue_valid = 1'b1; issue_op = OP_MUL; unit_result = 64'h2222_3333;
    @(posedge clk); #1;
    issue_valid = 1'b0; issue_op = OP_NOP;
    for (int k = 1; k <= 4; k++) begin
      unit_done = (k == 2);
      exception_flush = (k == 3);
      @(negedge clk);
      if (k == 3) begin
        check("done_flush_we", hilo_we, 1);
        check("done_flush_wdata", hilo_wdata, 64'h2222_3333);
      end
      if (k == 4) check("after_done_we", hilo_we, 0);
      @(posedge clk); #1;
    end
    unit_done = 1'b0;
    exception_flush = 1'b0;

    // Issue together with flush, and a non-muldiv op: both ignored.
    issue_valid = 1'b1; issue_op = OP_MADD; exception_flush = 1'b1;
    @(negedge clk);
    check("madd_flush_stall", stall_o, 0);
    @(posedge clk); #1;
    exception_flush = 1'b0; issue_op = 8'h01;
    @(negedge clk);
    check("madd_flush_busy", busy, 0);
    check("op01_stall", stall_o, 0);
    @(posedge clk); #1;
    issue_valid = 1'b0; issue_op = OP_NOP;
    @(negedge clk);
    check("op01_busy", busy, 0);
    @(posedge clk); #1;

    // Async reset mid-RUN, between edges.
    issue_valid = 1'b1; issue_op = OP_DIV; issue_a = 32'd9; issue_b = 32'd3; issue_unsigned = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0; issue_op = OP_NOP;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_unit_op", unit_op, OP_NOP);
    check("arst_busy", busy, 0);
    check("arst_stall", stall_o, 0);
    check("arst_unit_a", unit_a, 0);
    check("arst_unit_b", unit_b, 0);
    check("arst_uns", unit_unsigned, 0);
    check("arst_wdata", hilo_wdata, 64'h0);
    check("arst_we", hilo_we, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op('{OP_MADD, 1'b0, 32'd2, 32'd5, 64'h0000000A_00000000, 64'h0000000A_0000000A, 2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
